// File: rtl/wb_timer.sv
// Machine timer (mtime/mtimecmp) behind a pipelined Wishbone slave, raising timer_irq for the core.
// Latency: ack and read data one cycle after acceptance; timer_irq one cycle after its compare condition.
// Backpressure: never stalls; an ack is dropped if wb_cyc_i falls before it is driven.
module wb_timer #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic        timer_irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          en;
    logic          ie;
    logic          ack_q;
    logic          req;
    logic          wr;
    logic          tick;
    logic [2:0]    off;
    logic [31:0]   rd_mux;
    logic          unused_adr;

    // Only the word offset selects a register; the rest of the address is ignored.
    assign off        = wb_adr_i[4:2];
    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

    assign req        = wb_cyc_i & wb_stb_i;
    assign wr         = req & wb_we_i;
    assign tick       = en & (pre_cnt == PRE_MAX);
    assign wb_stall_o = 1'b0;
    // An ack whose cycle was abandoned is simply not shown.
    assign wb_ack_o   = ack_q & wb_cyc_i;

    // Replace only the enabled byte lanes of a 32-bit word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return r;
    endfunction

    // Read mux over the pre-update register values.
    always_comb begin
        rd_mux = 32'h0;
        case (off)
            3'd0:    rd_mux = mtime[31:0];
            3'd1:    rd_mux = mtime[63:32];
            3'd2:    rd_mux = mtimecmp[31:0];
            3'd3:    rd_mux = mtimecmp[63:32];
            3'd4:    rd_mux = {30'h0, ie, en};
            default: rd_mux = 32'h0;
        endcase
    end

    // Prescaler: counts enabled cycles, held at zero while the timer is stopped.
    always_ff @(posedge clk) begin
        if (!rst_n)      pre_cnt <= '0;
        else if (!en)    pre_cnt <= '0;
        else if (tick)   pre_cnt <= '0;
        else             pre_cnt <= pre_cnt + PW'(1);
    end

    // mtime: a bus write to either half overrides that cycle's increment entirely.
    always_ff @(posedge clk) begin
        if (!rst_n)                   mtime         <= 64'h0;
        else if (wr && off == 3'd0)   mtime[31:0]   <= lane_merge(mtime[31:0], wb_dat_i, wb_sel_i);
        else if (wr && off == 3'd1)   mtime[63:32]  <= lane_merge(mtime[63:32], wb_dat_i, wb_sel_i);
        else if (tick)                mtime         <= mtime + 64'd1;
    end

    // mtimecmp halves, byte-lane writable.
    always_ff @(posedge clk) begin
        if (!rst_n)                   mtimecmp        <= CMP_RESET;
        else if (wr && off == 3'd2)   mtimecmp[31:0]  <= lane_merge(mtimecmp[31:0], wb_dat_i, wb_sel_i);
        else if (wr && off == 3'd3)   mtimecmp[63:32] <= lane_merge(mtimecmp[63:32], wb_dat_i, wb_sel_i);
    end

    // CTRL: only byte lane 0 carries the EN and IE bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en <= 1'b1;
            ie <= 1'b0;
        end else if (wr && off == 3'd4 && wb_sel_i[0]) begin
            en <= wb_dat_i[0];
            ie <= wb_dat_i[1];
        end
    end

    // Bus response: one ack per accepted request, data captured at acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            ack_q <= req;
            if (req) wb_dat_o <= rd_mux;
        end
    end

    // Interrupt level from the register values of the previous edge.
    always_ff @(posedge clk) begin
        if (!rst_n) timer_irq <= 1'b0;
        else        timer_irq <= (mtime >= mtimecmp) & ie;
    end

endmodule

// File: tb/tb_wb_timer.sv
// Bench for wb_timer: two instances (prescale 1 and 4) share one bus; a table of bus rows
// is driven cycle by cycle and checked against constants and a behavioural timer model,
// followed by a long run of random rows checked against the same model.
module tb_wb_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic [31:0] dat1, dat4;
    logic        stall1, stall4, ack1, ack4, irq1, irq4;

    always #5 clk = ~clk;

    wb_timer #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(dat1),
        .wb_stall_o(stall1), .wb_ack_o(ack1), .timer_irq(irq1));

    wb_timer #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(dat4),
        .wb_stall_o(stall4), .wb_ack_o(ack4), .timer_irq(irq4));

    // One bus row per clock. cd: check the ack data of this request against x1 (prescale 1)
    // and/or x4 (prescale 4). ci/xirq: expected irq (prescale 1) seen in this row's cycle.
    // cna: no ack may be visible in this row's cycle.
    typedef struct packed {
        bit        rst;
        bit        cyc;
        bit        stb;
        bit        we;
        bit [2:0]  off;
        bit [3:0]  sel;
        bit [31:0] dat;
        bit [1:0]  cd;
        bit [31:0] x1;
        bit [31:0] x4;
        bit        ci;
        bit        xirq;
        bit        cna;
    } op_t;

    op_t ops[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    // ---------------- behavioural reference model ----------------
    // mtime is a plain 64-bit number that gains 1 after every P enabled cycles.
    logic [63:0] m_mt[2];
    logic [63:0] m_cmp[2];
    bit          m_en[2], m_ie[2], m_ack[2], m_irq[2];
    int          m_cnt[2];
    logic [31:0] m_dat[2];

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mread(input int k, input logic [2:0] o);
        case (o)
            3'd0: return m_mt[k][31:0];
            3'd1: return m_mt[k][63:32];
            3'd2: return m_cmp[k][31:0];
            3'd3: return m_cmp[k][63:32];
            3'd4: return {30'h0, m_ie[k], m_en[k]};
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] mk_rd;
    logic [63:0] mk_nm;
    bit          mk_req, mk_irq;
    int          mk_p;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mk_p = (k == 0) ? 1 : 4;
            if (!rst_n) begin
                m_mt[k] = 64'h0; m_cmp[k] = 64'hFFFF_FFFF_FFFF_FFFF;
                m_en[k] = 1'b1;  m_ie[k]  = 1'b0; m_cnt[k] = 0;
                m_ack[k] = 1'b0; m_dat[k] = 32'h0; m_irq[k] = 1'b0;
            end else begin
                mk_req = wb_cyc_i & wb_stb_i;
                mk_rd  = mread(k, wb_adr_i[4:2]);
                mk_irq = (m_mt[k] >= m_cmp[k]) && m_ie[k];
                mk_nm  = m_mt[k];
                if (m_en[k]) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == mk_p) begin
                        m_cnt[k] = 0;
                        mk_nm = m_mt[k] + 64'd1;
                    end
                end else begin
                    m_cnt[k] = 0;
                end
                if (mk_req && wb_we_i) begin
                    case (wb_adr_i[4:2])
                        3'd0: mk_nm = {m_mt[k][63:32], bmerge(m_mt[k][31:0], wb_dat_i, wb_sel_i)};
                        3'd1: mk_nm = {bmerge(m_mt[k][63:32], wb_dat_i, wb_sel_i), m_mt[k][31:0]};
                        3'd2: m_cmp[k][31:0]  = bmerge(m_cmp[k][31:0], wb_dat_i, wb_sel_i);
                        3'd3: m_cmp[k][63:32] = bmerge(m_cmp[k][63:32], wb_dat_i, wb_sel_i);
                        3'd4: if (wb_sel_i[0]) begin
                                  m_en[k] = wb_dat_i[0];
                                  m_ie[k] = wb_dat_i[1];
                              end
                        default: ;
                    endcase
                end
                m_mt[k]  = mk_nm;
                m_ack[k] = mk_req;
                if (mk_req) m_dat[k] = mk_rd;
                m_irq[k] = mk_irq;
            end
        end
    end

    // ---------------- row builders ----------------
    function automatic op_t mk(bit cyc, bit stb, bit we, bit [2:0] off, bit [3:0] sel, bit [31:0] dat);
        op_t o;
        o = '0;
        o.cyc = cyc; o.stb = stb; o.we = we; o.off = off; o.sel = sel; o.dat = dat;
        return o;
    endfunction
    function automatic op_t W(bit [2:0] off, bit [31:0] dat);
        return mk(1, 1, 1, off, 4'hF, dat);
    endfunction
    function automatic op_t WS(bit [2:0] off, bit [31:0] dat, bit [3:0] sel);
        return mk(1, 1, 1, off, sel, dat);
    endfunction
    function automatic op_t R(bit [2:0] off);
        return mk(1, 1, 0, off, 4'hF, 32'h0);
    endfunction
    function automatic op_t RX(bit [2:0] off, bit [31:0] x1, bit [31:0] x4);
        op_t o;
        o = R(off); o.cd = 2'b11; o.x1 = x1; o.x4 = x4;
        return o;
    endfunction
    function automatic op_t RX1(bit [2:0] off, bit [31:0] x1);
        op_t o;
        o = R(off); o.cd = 2'b01; o.x1 = x1;
        return o;
    endfunction
    function automatic op_t IDLE();
        return mk(1, 0, 0, 3'd0, 4'h0, 32'h0);
    endfunction
    function automatic op_t IRQ(bit x);
        op_t o;
        o = IDLE(); o.ci = 1'b1; o.xirq = x;
        return o;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input op_t o);
        rst_n    = !o.rst;
        wb_cyc_i = o.cyc;
        wb_stb_i = o.stb;
        wb_we_i  = o.we;
        wb_sel_i = o.sel;
        wb_dat_i = o.dat;
        wb_adr_i = $urandom();
        wb_adr_i[4:2] = o.off;
    endtask

    task automatic check_cycle(input op_t prev, input op_t cur);
        chk("stall_p1", {31'h0, stall1}, 32'h0);
        chk("stall_p4", {31'h0, stall4}, 32'h0);
        chk("ack_p1", {31'h0, ack1}, {31'h0, m_ack[0] & wb_cyc_i});
        chk("ack_p4", {31'h0, ack4}, {31'h0, m_ack[1] & wb_cyc_i});
        if (m_ack[0] && wb_cyc_i) chk("dat_p1", dat1, m_dat[0]);
        if (m_ack[1] && wb_cyc_i) chk("dat_p4", dat4, m_dat[1]);
        chk("irq_p1", {31'h0, irq1}, {31'h0, m_irq[0]});
        chk("irq_p4", {31'h0, irq4}, {31'h0, m_irq[1]});
        if (prev.cd[0]) begin
            chk("tbl_ack_p1", {31'h0, ack1}, 32'h1);
            chk("tbl_dat_p1", dat1, prev.x1);
        end
        if (prev.cd[1]) begin
            chk("tbl_ack_p4", {31'h0, ack4}, 32'h1);
            chk("tbl_dat_p4", dat4, prev.x4);
        end
        if (cur.cna) begin
            chk("tbl_noack_p1", {31'h0, ack1}, 32'h0);
            chk("tbl_noack_p4", {31'h0, ack4}, 32'h0);
        end
        if (cur.ci) chk("tbl_irq_p1", {31'h0, irq1}, {31'h0, cur.xirq});
    endtask

    // Drive each row from one falling edge to the next; outputs are sampled 1 time unit
    // after the row is driven, so an ack belongs to the previous row's request.
    task automatic run_ops();
        op_t prev, cur;
        prev = '0;
        for (int i = 0; i <= ops.size(); i++) begin
            cur = (i < ops.size()) ? ops[i] : IDLE();
            @(negedge clk);
            drive(cur);
            #1;
            check_cycle(prev, cur);
            prev = cur;
        end
        ops.delete();
    endtask

    // ---------------- test ----------------
    initial begin
        op_t o;
        drive(mk(0, 0, 0, 3'd0, 4'h0, 32'h0));
        rst_n = 1'b0;
        repeat (3) @(posedge clk);

        // Reset values, then free-running count from reset.
        o = IDLE(); o.rst = 1'b1; ops.push_back(o);
        o = IRQ(0); o.cna = 1'b1; ops.push_back(o);
        repeat (9) ops.push_back(IDLE());
        ops.push_back(RX(3'd0, 32'd10, 32'd2));
        ops.push_back(RX(3'd1, 32'h0, 32'h0));
        ops.push_back(RX(3'd4, 32'h1, 32'h1));
        ops.push_back(RX(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        ops.push_back(RX(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF));

        // Register access with the timer stopped, byte lanes and unmapped offsets.
        ops.push_back(W(3'd4, 32'h0));
        ops.push_back(W(3'd0, 32'h1234_5678));
        ops.push_back(RX(3'd0, 32'h1234_5678, 32'h1234_5678));
        ops.push_back(W(3'd1, 32'h0000_CAFE));
        ops.push_back(RX(3'd1, 32'h0000_CAFE, 32'h0000_CAFE));
        ops.push_back(RX(3'd4, 32'h0, 32'h0));
        ops.push_back(WS(3'd2, 32'h0000_AB00, 4'b0010));
        ops.push_back(RX(3'd2, 32'hFFFF_ABFF, 32'hFFFF_ABFF));
        ops.push_back(W(3'd6, 32'hDEAD_BEEF));
        ops.push_back(RX(3'd6, 32'h0, 32'h0));
        ops.push_back(RX(3'd2, 32'hFFFF_ABFF, 32'hFFFF_ABFF));
        ops.push_back(RX(3'd0, 32'h1234_5678, 32'h1234_5678));
        ops.push_back(RX(3'd1, 32'h0000_CAFE, 32'h0000_CAFE));
        ops.push_back(RX(3'd5, 32'h0, 32'h0));
        ops.push_back(RX(3'd7, 32'h0, 32'h0));
        ops.push_back(WS(3'd0, 32'hFFFF_FFFF, 4'b0101));
        ops.push_back(RX(3'd0, 32'h12FF_56FF, 32'h12FF_56FF));
        ops.push_back(WS(3'd4, 32'h3, 4'b1110));
        ops.push_back(RX(3'd4, 32'h0, 32'h0));
        ops.push_back(W(3'd4, 32'hFFFF_FFFF));
        ops.push_back(RX(3'd4, 32'h3, 32'h3));
        ops.push_back(W(3'd4, 32'h0));

        // LO->HI carry, then 64-bit wrap from all-ones.
        ops.push_back(W(3'd4, 32'h1));
        ops.push_back(W(3'd0, 32'hFFFF_FFFE));
        ops.push_back(W(3'd1, 32'h0));
        repeat (3) ops.push_back(IDLE());
        ops.push_back(RX1(3'd0, 32'h1));
        ops.push_back(RX1(3'd1, 32'h1));
        ops.push_back(W(3'd4, 32'h0));
        ops.push_back(W(3'd0, 32'hFFFF_FFFF));
        ops.push_back(W(3'd1, 32'hFFFF_FFFF));
        ops.push_back(W(3'd4, 32'h1));
        ops.push_back(IDLE());
        ops.push_back(RX1(3'd0, 32'h0));
        ops.push_back(RX1(3'd1, 32'h0));

        // Interrupt rise at mtime == mtimecmp, fall after raising mtimecmp.
        ops.push_back(W(3'd4, 32'h0));
        ops.push_back(W(3'd0, 32'd100));
        ops.push_back(W(3'd1, 32'h0));
        ops.push_back(W(3'd3, 32'h0));
        ops.push_back(W(3'd2, 32'd105));
        ops.push_back(W(3'd4, 32'h3));
        repeat (6) ops.push_back(IRQ(0));
        ops.push_back(IRQ(1));
        ops.push_back(IRQ(1));
        o = W(3'd3, 32'hFFFF_FFFF); o.ci = 1'b1; o.xirq = 1'b1; ops.push_back(o);
        ops.push_back(IRQ(1));
        ops.push_back(IRQ(0));

        // Back-to-back reads, then an abandoned cycle.
        ops.push_back(R(3'd0));
        ops.push_back(RX(3'd1, 32'h0, 32'h0));
        ops.push_back(RX(3'd2, 32'd105, 32'd105));
        ops.push_back(RX(3'd4, 32'h3, 32'h3));
        ops.push_back(IDLE());
        ops.push_back(R(3'd0));
        ops.push_back(R(3'd1));
        o = mk(0, 1, 0, 3'd2, 4'hF, 32'h0); o.cna = 1'b1; ops.push_back(o);
        o = mk(0, 1, 0, 3'd4, 4'hF, 32'h0); o.cna = 1'b1; ops.push_back(o);
        o = IDLE(); o.cna = 1'b1; ops.push_back(o);

        // Prescaler: 16 enabled cycles, then stopped for 20.
        ops.push_back(W(3'd4, 32'h0));
        ops.push_back(W(3'd0, 32'h0));
        ops.push_back(W(3'd1, 32'h0));
        ops.push_back(W(3'd4, 32'h1));
        repeat (16) ops.push_back(IDLE());
        ops.push_back(RX(3'd0, 32'd16, 32'd4));
        ops.push_back(W(3'd4, 32'h0));
        ops.push_back(RX(3'd0, 32'd18, 32'd4));
        repeat (20) ops.push_back(IDLE());
        ops.push_back(RX(3'd0, 32'd18, 32'd4));

        // Reset taken on a read: no ack, everything back to reset values.
        o = R(3'd0); o.rst = 1'b1; ops.push_back(o);
        o = IDLE(); o.cna = 1'b1; ops.push_back(o);
        ops.push_back(RX(3'd4, 32'h1, 32'h1));
        ops.push_back(RX(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        ops.push_back(RX(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        ops.push_back(RX(3'd1, 32'h0, 32'h0));
        ops.push_back(IRQ(0));
        run_ops();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            o = mk(($urandom_range(0, 9) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                   3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom());
            o.rst = ($urandom_range(0, 299) == 0);
            ops.push_back(o);
        end
        run_ops();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
